pueo_l2_meta_collect: RTL and testbench
=======================================

PUEO_L2_META_COLLECT -- requirements
Module: pueo_l2_meta_collect

Interface
REQ-001 Parameter HOLDOFF_CLKS, default 16: ce_i-qualified cycles that holdoff_o stays high after each accepted trigger.
REQ-002 Parameter FIFO_EVENTS, default 4: number of buffered events; a power of two, minimum 2.
REQ-003 clk_i  input  1  single clock for all logic.
REQ-004 rst_i  input  1  reset, synchronous to clk_i, active-high.
REQ-005 ce_i  input  1  clock enable (sysclk_x2 phase); qualifies the holdoff countdown only.
REQ-006 trig_i  input  1  L2 master trigger, single-clk pulse.
REQ-007 tio0_meta_i..tio3_meta_i  input  64 each  delay-matched per-TIO metadata, valid in the cycle trig_i is high.
REQ-008 holdoff_o  output  1  holdoff returned to the L2 trigger.
REQ-009 m_axis_tdata  output  64  event stream data.
REQ-010 m_axis_tvalid / m_axis_tlast  output  1 each  stream valid and end of event.
REQ-011 m_axis_tready  input  1  stream ready.
REQ-012 event_count_o  output  32  next event number to be assigned.
REQ-013 drop_count_o  output  16  number of dropped triggers, saturating.
REQ-014 overflow_o  output  1  sticky flag: at least one trigger was dropped.

Function
REQ-015 A trigger is sampled on every clk_i edge with trig_i=1, independent of ce_i.
- If the FIFO is not full: tio0-3 meta, event_count_o and the timestamp are written as one event entry on that edge.
- If the FIFO is full: the trigger is dropped, drop_count_o increments (saturating at 0xFFFF) and overflow_o is set.
REQ-016 event_count_o increments by 1 (mod 2^32) on every sampled trigger, accepted or dropped, so dropped triggers show as gaps in the event numbers.
REQ-017 The timestamp is a free-running 32-bit clk_i counter that wraps 0xFFFFFFFF->0.
REQ-018 Each event is emitted as exactly 5 beats:
- beat 0: {event_number[31:0], timestamp[31:0]}
- beats 1-4: tio0..tio3 meta
- tlast=1 only on beat 4.
REQ-019 Output FSM states:
- IDLE->HDR when the FIFO is non-empty.
- HDR->META on handshake.
- META advances its beat index 0..3 on each handshake.
- META beat 3 handshake->HDR if another event is queued, otherwise IDLE.
REQ-020 Latency: trigger sampled at edge N gives m_axis_tvalid=1 from the cycle after edge N+1 when the FIFO was empty and the FSM was IDLE.
REQ-021 While tvalid=1 and tready=0, tdata, tlast and tvalid hold stable.
REQ-022 The FIFO entry is freed on the beat-4 handshake. A write and a free in the same cycle leave the occupancy unchanged, and a write is permitted in a full-FIFO cycle that also frees an entry.
REQ-023 Holdoff counter:
- loaded with HOLDOFF_CLKS on each accepted trigger;
- decrements by 1 on each ce_i=1 cycle while non-zero;
- a reload while non-zero restarts the count.
REQ-024 holdoff_o = (holdoff counter != 0) OR FIFO full, registered. HOLDOFF_CLKS=0 makes holdoff_o follow FIFO full only.

Reset
REQ-025 On a clk_i edge with rst_i=1, the following clear to 0:
- FIFO occupancy, event_count_o, timestamp, drop_count_o, overflow_o, holdoff counter;
- holdoff_o, m_axis_tvalid, m_axis_tlast, m_axis_tdata;
- FSM returns to IDLE.
REQ-026 Reset mid-event discards all queued and partially sent events; tvalid is low in the first cycle after the reset edge, with no completion beat.
REQ-027 trig_i is ignored on any edge where rst_i=1.

Configuration
REQ-028 Macro PUEO_L2COLLECT_TIMESTAMP_EN:
- Defined: the timestamp counter exists and fills header bits [31:0].
- Not defined: the counter is not built, header bits [31:0] are 0, and all other behaviour is unchanged.

Verification
REQ-029 Single trigger, meta 0x1111..1/0x2222..2/0x3333..3/0x4444..4, tready=1 -> 5 beats: header event 0, then the meta in TIO order, tlast only on the 5th beat, tvalid from 2 cycles after the trigger.
REQ-030 tready=0, triggers forced past holdoff, 5 triggers -> holdoff_o=1 after the 4th; 5th dropped; drop_count_o=1; overflow_o=1; event_count_o=5; on release, events 0-3 stream in order.
REQ-031 HOLDOFF_CLKS=16, ce_i every 2nd clk, FIFO empty, one trigger -> holdoff_o high for exactly 32 clk.
REQ-032 Random tready toggling across 3 back-to-back events -> no beat lost or duplicated, and tdata stable during every stall.
REQ-033 rst_i pulsed during META beat 2 -> tvalid=0 the next cycle, all counters 0, and the next trigger yields event number 0.
REQ-034 FIFO full, trigger on the same edge as the beat-4 handshake -> trigger accepted, drop_count_o stays 0.

Source files
------------

// File: rtl/pueo_l2_meta_collect_if.sv
// Event stream bus for the L2 metadata collector: 64-bit data, valid/last
// from the producer, ready from the consumer.
`timescale 1ns/1ps
interface pueo_l2_meta_collect_if;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pueo_l2_meta_collect.sv
// L2 trigger metadata collector: buffers per-trigger TIO metadata and streams it as
// 5-beat events. Optional timestamp header field: define PUEO_L2COLLECT_TIMESTAMP_EN.
`timescale 1ns/1ps
module pueo_l2_meta_collect #(
  parameter int unsigned HOLDOFF_CLKS = 16,
  parameter int unsigned FIFO_EVENTS  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ce_i,
  input  logic                          trig_i,
  input  logic [63:0]                   tio0_meta_i,
  input  logic [63:0]                   tio1_meta_i,
  input  logic [63:0]                   tio2_meta_i,
  input  logic [63:0]                   tio3_meta_i,
  output logic                          holdoff_o,
  pueo_l2_meta_collect_if.master        m_axis,
  output logic [31:0]                   event_count_o,
  output logic [15:0]                   drop_count_o,
  output logic                          overflow_o
);

  localparam int unsigned AW = $clog2(FIFO_EVENTS);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = (HOLDOFF_CLKS > 0) ? $clog2(HOLDOFF_CLKS + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_META} state_t;

  logic [63:0]   r_hdr_mem  [FIFO_EVENTS];
  logic [63:0]   r_meta_mem [FIFO_EVENTS][4];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_event_cnt;
  logic [15:0]   r_drop_cnt;
  logic          r_overflow;
  logic [HW-1:0] r_hold;
  logic          r_holdoff;

  state_t        r_state;
  logic [1:0]    r_beat;
  logic [63:0]   r_tdata;
  logic          r_tvalid;
  logic          r_tlast;

  logic          w_full;
  logic          w_hs;
  logic          w_free;
  logic          w_accept;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic [31:0]   w_ts;
  logic [AW-1:0] w_rd_next;

`ifdef PUEO_L2COLLECT_TIMESTAMP_EN
  logic [31:0] r_ts;
  always_ff @(posedge clk_i) begin
    if (rst_i) r_ts <= '0;
    else       r_ts <= r_ts + 32'd1;
  end
  assign w_ts = r_ts;
`else
  assign w_ts = '0;
`endif

  assign w_full    = (r_count == CW'(FIFO_EVENTS));
  assign w_hs      = r_tvalid & m_axis.tready;
  assign w_free    = w_hs & (r_state == S_META) & (r_beat == 2'd3);
  // The slot freed by the final beat may be refilled on the same edge.
  assign w_accept  = trig_i & (~w_full | w_free);
  assign w_drop    = trig_i & w_full & ~w_free;
  assign w_rd_next = r_rd_ptr + 1'b1;

  always_comb begin
    w_count_nxt = r_count;
    if (w_accept && !w_free)      w_count_nxt = r_count + 1'b1;
    else if (!w_accept && w_free) w_count_nxt = r_count - 1'b1;
  end

  always_comb begin
    w_hold_nxt = r_hold;
    if (w_accept)                   w_hold_nxt = HW'(HOLDOFF_CLKS);
    else if (ce_i && r_hold != '0)  w_hold_nxt = r_hold - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_accept) begin
      r_hdr_mem[r_wr_ptr]     <= {r_event_cnt, w_ts};
      r_meta_mem[r_wr_ptr][0] <= tio0_meta_i;
      r_meta_mem[r_wr_ptr][1] <= tio1_meta_i;
      r_meta_mem[r_wr_ptr][2] <= tio2_meta_i;
      r_meta_mem[r_wr_ptr][3] <= tio3_meta_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_event_cnt <= '0;
      r_drop_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_hold      <= '0;
      r_holdoff   <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_free)   r_rd_ptr <= w_rd_next;
      r_count <= w_count_nxt;
      if (trig_i) r_event_cnt <= r_event_cnt + 32'd1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      r_hold    <= w_hold_nxt;
      r_holdoff <= (w_hold_nxt != '0) | (w_count_nxt == CW'(FIFO_EVENTS));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_state  <= S_HDR;
            r_tdata  <= r_hdr_mem[r_rd_ptr];
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
          end
        end
        S_HDR: begin
          if (w_hs) begin
            r_state <= S_META;
            r_beat  <= 2'd0;
            r_tdata <= r_meta_mem[r_rd_ptr][0];
          end
        end
        S_META: begin
          if (w_hs) begin
            if (r_beat == 2'd3) begin
              // Chain straight into the next header only for an event already stored.
              if (r_count > CW'(1)) begin
                r_state <= S_HDR;
                r_tdata <= r_hdr_mem[w_rd_next];
                r_tlast <= 1'b0;
              end else begin
                r_state  <= S_IDLE;
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
              end
            end else begin
              r_beat  <= r_beat + 2'd1;
              r_tdata <= r_meta_mem[r_rd_ptr][r_beat + 2'd1];
              r_tlast <= (r_beat == 2'd2);
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign holdoff_o     = r_holdoff;
  assign event_count_o = r_event_cnt;
  assign drop_count_o  = r_drop_cnt;
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_pueo_l2_meta_collect.sv
// Self-checking bench for pueo_l2_meta_collect: directed vector table, corner-case
// sequences, and randomized traffic checked against an event-queue reference model.
`timescale 1ns/1ps
module tb_pueo_l2_meta_collect;

  localparam int unsigned HOLD = 16;
  localparam int unsigned FIFO = 4;
`ifdef PUEO_L2COLLECT_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        trig = 1'b0;
  logic [63:0] meta0 = '0, meta1 = '0, meta2 = '0, meta3 = '0;
  logic        holdoff;
  logic [31:0] event_count;
  logic [15:0] drop_count;
  logic        overflow;

  pueo_l2_meta_collect_if m_axis_if ();

  pueo_l2_meta_collect #(.HOLDOFF_CLKS(HOLD), .FIFO_EVENTS(FIFO)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ce_i          (ce),
    .trig_i        (trig),
    .tio0_meta_i   (meta0),
    .tio1_meta_i   (meta1),
    .tio2_meta_i   (meta2),
    .tio3_meta_i   (meta3),
    .holdoff_o     (holdoff),
    .m_axis        (m_axis_if),
    .event_count_o (event_count),
    .drop_count_o  (drop_count),
    .overflow_o    (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    $display("FAIL %s: got no event within bound, expected event", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst  = 1'b1;
    trig = 1'b0;
    tick();
    rst  = 1'b0;
  endtask

  // Reference model: evaluated on the falling edge, predicting the next rising edge.
  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned m_occ = 0;
  logic [31:0] m_evt = '0;
  logic [15:0] m_drop = '0;
  logic        m_ovf = 1'b0;
  int unsigned m_hold = 0;
  logic        m_holdoff = 1'b0;
  logic [31:0] m_ts = '0;
  int unsigned m_pos = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin : model_blk
    logic  hs, freed, acc;
    beat_t b;
    check("event_count", event_count, m_evt);
    check("drop_count", drop_count, m_drop);
    check("overflow", overflow, m_ovf);
    check("holdoff", holdoff, m_holdoff);
    if (m_axis_if.tvalid === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_beat", m_axis_if.tdata, 64'hx);
      else begin
        check("tdata", m_axis_if.tdata, exp_q[0].d);
        check("tlast", m_axis_if.tlast, exp_q[0].l);
      end
    end
    if (prev_stall) begin
      check("stall_valid", m_axis_if.tvalid, 1);
      check("stall_data", m_axis_if.tdata, prev_data);
      check("stall_last", m_axis_if.tlast, prev_last);
    end

    hs = m_axis_if.tvalid && m_axis_if.tready;
    if (rst) begin
      exp_q.delete();
      m_occ = 0; m_evt = '0; m_drop = '0; m_ovf = 1'b0;
      m_hold = 0; m_holdoff = 1'b0; m_ts = '0; m_pos = 0;
      prev_stall = 1'b0;
    end else begin
      prev_stall = m_axis_if.tvalid && !m_axis_if.tready;
      prev_data  = m_axis_if.tdata;
      prev_last  = m_axis_if.tlast;
      freed = 1'b0;
      if (hs) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        freed = (m_pos == 4);
        m_pos = (m_pos + 1) % 5;
      end
      acc = trig && (m_occ < FIFO || freed);
      if (trig) begin
        if (acc) begin
          b.d = {m_evt, (TS_EN ? m_ts : 32'd0)}; b.l = 1'b0; exp_q.push_back(b);
          b.d = meta0; exp_q.push_back(b);
          b.d = meta1; exp_q.push_back(b);
          b.d = meta2; exp_q.push_back(b);
          b.d = meta3; b.l = 1'b1; exp_q.push_back(b);
        end else begin
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          m_ovf = 1'b1;
        end
        m_evt = m_evt + 32'd1;
      end
      if (acc) m_hold = HOLD;
      else if (ce && m_hold != 0) m_hold = m_hold - 1;
      m_occ = m_occ + (acc ? 1 : 0) - (freed ? 1 : 0);
      m_ts  = m_ts + 32'd1;
      m_holdoff = (m_hold != 0) || (m_occ == FIFO);
    end
  end

  typedef struct {
    logic        trig;
    logic        exp_valid;
    logic        exp_last;
    logic [63:0] exp_data;
    logic        exp_hold;
    logic [31:0] exp_evt;
  } row_t;

  row_t rows[7];

  initial begin
    int unsigned hcount, beats;
    bit found;
    m_axis_if.tready = 1'b1;

    rows[0] = '{1'b1, 1'b0, 1'b0, 64'h0,                  1'b1, 32'd1};
    rows[1] = '{1'b0, 1'b1, 1'b0, 64'h0,                  1'b1, 32'd1};
    rows[2] = '{1'b0, 1'b1, 1'b0, 64'h1111111111111111,   1'b1, 32'd1};
    rows[3] = '{1'b0, 1'b1, 1'b0, 64'h2222222222222222,   1'b1, 32'd1};
    rows[4] = '{1'b0, 1'b1, 1'b0, 64'h3333333333333333,   1'b1, 32'd1};
    rows[5] = '{1'b0, 1'b1, 1'b1, 64'h4444444444444444,   1'b1, 32'd1};
    rows[6] = '{1'b0, 1'b0, 1'b0, 64'h4444444444444444,   1'b1, 32'd1};

    tick();
    tick();
    check("rst_tvalid", m_axis_if.tvalid, 0);
    check("rst_tdata", m_axis_if.tdata, 0);
    check("rst_holdoff", holdoff, 0);
    rst = 1'b0;

    // Single trigger, ready held high: latency and beat order.
    meta0 = 64'h1111111111111111; meta1 = 64'h2222222222222222;
    meta2 = 64'h3333333333333333; meta3 = 64'h4444444444444444;
    for (int i = 0; i < 7; i++) begin
      trig = rows[i].trig;
      tick();
      check($sformatf("row%0d_tvalid", i), m_axis_if.tvalid, rows[i].exp_valid);
      if (rows[i].exp_valid) begin
        check($sformatf("row%0d_tdata", i), m_axis_if.tdata, rows[i].exp_data);
        check($sformatf("row%0d_tlast", i), m_axis_if.tlast, rows[i].exp_last);
      end
      check($sformatf("row%0d_holdoff", i), holdoff, rows[i].exp_hold);
      check($sformatf("row%0d_evt", i), event_count, rows[i].exp_evt);
    end

    // Holdoff duration with ce on every second clock, aligned to the trigger edge.
    do_reset();
    hcount = 0;
    for (int c = 0; c < 60; c++) begin
      trig = (c == 0);
      ce   = (c % 2 == 0);
      tick();
      if (holdoff) hcount++;
    end
    trig = 1'b0; ce = 1'b0;
    check("holdoff_32clk", hcount, 32);

    // Five triggers into a stalled stream: fifth is dropped.
    do_reset();
    m_axis_if.tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      meta0 = {$urandom, $urandom}; meta1 = {$urandom, $urandom};
      meta2 = {$urandom, $urandom}; meta3 = {$urandom, $urandom};
      trig = 1'b1;
      tick();
      if (k == 3) check("full_holdoff", holdoff, 1);
    end
    trig = 1'b0;
    check("ovf_drop", drop_count, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_evt", event_count, 5);
    check("ovf_hdr_valid", m_axis_if.tvalid, 1);
    check("ovf_hdr_evt", m_axis_if.tdata[63:32], 0);
    m_axis_if.tready = 1'b1;
    beats = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_axis_if.tvalid && m_axis_if.tready) beats++;
      tick();
    end
    check("ovf_beats", beats, 20);

    // Trigger on the same edge as the final-beat handshake of a full FIFO.
    do_reset();
    m_axis_if.tready = 1'b0;
    trig = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    trig = 1'b0;
    m_axis_if.tready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      tick();
      if (m_axis_if.tvalid && m_axis_if.tlast) found = 1'b1;
    end
    if (!found) fail_bound("full_free_wait");
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("full_free_drop", drop_count, 0);
    check("full_free_ovf", overflow, 0);
    check("full_free_evt", event_count, 5);
    check("full_free_holdoff", holdoff, 1);
    for (int c = 0; c < 40; c++) tick();

    // Reset mid-event while the third meta beat is presented.
    do_reset();
    meta0 = 64'hA0A0_0000_0000_0000; meta1 = 64'hA1A1_0000_0000_0001;
    meta2 = 64'hA2A2_0000_0000_0002; meta3 = 64'hA3A3_0000_0000_0003;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (m_axis_if.tvalid && m_axis_if.tdata == 64'hA2A2_0000_0000_0002) found = 1'b1;
    end
    if (!found) fail_bound("midrst_wait");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_tvalid", m_axis_if.tvalid, 0);
    check("midrst_tlast", m_axis_if.tlast, 0);
    check("midrst_tdata", m_axis_if.tdata, 0);
    check("midrst_evt", event_count, 0);
    check("midrst_drop", drop_count, 0);
    check("midrst_holdoff", holdoff, 0);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    check("midrst_next_valid", m_axis_if.tvalid, 1);
    check("midrst_next_evt", m_axis_if.tdata[63:32], 0);
    for (int c = 0; c < 10; c++) tick();

    // Randomized traffic: three back-to-back events, then mixed triggers and stalls.
    do_reset();
    for (int c = 0; c < 1800; c++) begin
      trig = (c < 3) ? 1'b1 : (c > 200 && $urandom_range(0, 9) == 0);
      m_axis_if.tready = $urandom_range(0, 1);
      ce = $urandom_range(0, 1);
      meta0 = {$urandom, $urandom}; meta1 = {$urandom, $urandom};
      meta2 = {$urandom, $urandom}; meta3 = {$urandom, $urandom};
      tick();
    end
    trig = 1'b0;
    m_axis_if.tready = 1'b1;
    for (int c = 0; c < 60; c++) tick();
    check("drain_empty", exp_q.size(), 0);
    check("drain_tvalid", m_axis_if.tvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
